// File: rtl/stall_data_memory_pkg.sv
// Shared definitions for the stalling data memory: FSM state encoding and
// default sizing constants.
package stall_data_memory_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_RD_LAT = 2;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/stall_data_memory_be_ram.sv
// Single-port synchronous RAM with byte-lane write enables; read data is
// registered and holds until the next read. No reset by design.
module be_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        be,
    output logic [DATA_W-1:0]          rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/stall_data_memory.sv
// Data memory with a request/response handshake, configurable read latency
// and a power-up zeroing sweep; mem_stall tells the pipeline to hold.
module stall_data_memory
    import stall_data_memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [DATA_W/8-1:0]  req_be,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_stall
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state;
    logic [IDX_W-1:0]    init_idx;
    logic [CNT_W-1:0]    cnt;
    logic                ready_q;
    logic                rsp_valid_q;
    logic                err_q;
    logic                rd_err;
    logic                from_ram;
    logic [DATA_W-1:0]   rdata_q;

    logic [ADDR_W-1:0]   word_addr;
    logic [IDX_W-1:0]    acc_idx;
    logic                misalign;
    logic                oor;
    logic                acc_err;

    logic                ram_en;
    logic                ram_we;
    logic [IDX_W-1:0]    ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [NB-1:0]       ram_be;
    logic [DATA_W-1:0]   ram_rdata;

    assign word_addr = req_addr >> OFF_W;
    assign misalign  = (req_addr[OFF_W-1:0] != '0);
    assign oor       = (64'(word_addr) >= 64'(DEPTH));
    assign acc_err   = misalign | oor;
    assign acc_idx   = word_addr[IDX_W-1:0];

    // Memory port is idle during reset so only the INIT sweep defines contents.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = init_idx;
        ram_wdata = '0;
        ram_be    = '1;
        if (rst) begin
            case (state)
                INIT: begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                end
                IDLE: begin
                    if (req_valid && !acc_err) begin
                        ram_en    = 1'b1;
                        ram_we    = req_we;
                        ram_addr  = acc_idx;
                        ram_wdata = req_wdata;
                        ram_be    = req_be;
                    end
                end
                default: ;
            endcase
        end
    end

    be_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .be    (ram_be),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= INIT;
            init_idx    <= '0;
            cnt         <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rd_err      <= 1'b0;
            from_ram    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                INIT: begin
                    if (init_idx == IDX_W'(DEPTH - 1)) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        init_idx <= init_idx + IDX_W'(1);
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        ready_q <= 1'b0;
                        if (req_we || RD_LAT == 1) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            err_q       <= acc_err;
                            from_ram    <= !req_we && !acc_err;
                            rdata_q     <= '0;
                        end else begin
                            state  <= RD_WAIT;
                            cnt    <= CNT_W'(RD_LAT - 1);
                            rd_err <= acc_err;
                        end
                    end
                end
                RD_WAIT: begin
                    // Leave when the decremented count reaches zero so the
                    // response lands RD_LAT edges after acceptance.
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        err_q       <= rd_err;
                        from_ram    <= !rd_err;
                        rdata_q     <= '0;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    ready_q  <= 1'b1;
                    from_ram <= 1'b0;
                    if (from_ram) begin
                        rdata_q <= ram_rdata;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // RAM output is only valid from the RESP cycle, so it is forwarded there
    // and captured into rdata_q for holding afterwards.
    assign rsp_rdata = from_ram ? ram_rdata : rdata_q;
    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = err_q;
    assign mem_stall = ~ready_q;

endmodule

// File: doc/stall_data_memory.md
STALL_DATA_MEMORY -- requirements
Module: stall_data_memory

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 1024, word count; power of two, 16..65536.
REQ-003 Parameter RD_LAT, default 2, read latency in cycles; legal range 1..8.
REQ-004 Parameter ADDR_W, default 32, byte-address width.
REQ-005 clk  in  1  clock; all logic samples on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  1  access request present.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 req_be  in  DATA_W/8  byte-lane write enables.
REQ-012 req_ready  out  1  request accepted this cycle when req_valid & req_ready.
REQ-013 rsp_valid  out  1  one-cycle pulse marking read data or write completion.
REQ-014 rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-015 rsp_err  out  1  out-of-range or misaligned access, valid with rsp_valid.
REQ-016 mem_stall  out  1  pipeline stall, equal to ~req_ready.

Function
REQ-017 Word index SHALL be req_addr >> log2(DATA_W/8); low address bits nonzero -> misaligned.
REQ-018 Word index >= DEPTH SHALL be out-of-range.
REQ-019 FSM states SHALL be INIT, IDLE, RD_WAIT and RESP.
REQ-020 INIT SHALL write zero to one word per cycle, index 0..DEPTH-1, then go to IDLE; req_ready = 0 throughout.
REQ-021 IDLE SHALL assert req_ready = 1.
REQ-022 Accepted write in IDLE SHALL update only the lanes whose req_be bit is set, on the acceptance edge.
REQ-023 Accepted write SHALL go to RESP; rsp_valid is asserted the next cycle, with rsp_rdata = 0.
REQ-024 Accepted read SHALL latch the index and go to RD_WAIT with a counter loaded to RD_LAT-1.
REQ-025 RD_WAIT SHALL decrement the counter each cycle; at 0 it goes to RESP.
REQ-026 A read SHALL present rsp_valid exactly RD_LAT cycles after the acceptance edge, with data as stored at acceptance.
REQ-027 With RD_LAT = 1, the read SHALL go directly from IDLE to RESP.
REQ-028 RESP SHALL pulse rsp_valid for one cycle, hold req_ready = 0, and return to IDLE.
REQ-029 Throughput SHALL be at most one access per RD_LAT+1 cycles for reads and one per 2 cycles for writes.
REQ-030 An errored access SHALL not modify memory, SHALL return rsp_rdata = 0 and rsp_err = 1, and SHALL follow normal timing.
REQ-031 req_be = 0 on a write SHALL be a legal no-op that still produces a response.
REQ-032 rsp_rdata and rsp_err SHALL hold their values until the next rsp_valid pulse.
REQ-033 Inputs SHALL be ignored whenever req_ready = 0; the requester holds them stable until accepted.

Reset
REQ-034 rst = 0 on a clock edge SHALL force state INIT, init index 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-035 Reset asserted mid-read or mid-INIT SHALL abandon the operation, produce no response, and restart INIT from index 0.
REQ-036 Memory contents SHALL be defined only by the INIT sweep, not by a parallel reset clear.

Structure
REQ-037 A shared package SHALL hold the FSM state enum and the default DATA_W, DEPTH and RD_LAT constants.
REQ-038 The storage array SHALL be a sub-module, be_ram, with one synchronous read/write port and byte-lane write enables.
REQ-039 be_ram SHALL contain no reset logic.

Verification
REQ-040 Release reset -> req_ready stays 0 for exactly DEPTH cycles and then rises; a read of word 5 returns 0.
REQ-041 Write addr 0x10, data 0xDEADBEEF, be 0xF; then read 0x10 with RD_LAT = 2 -> rsp_valid 2 cycles after acceptance, rdata 0xDEADBEEF, err 0.
REQ-042 Write addr 0x10, data 0x11223344, be 0x5 over 0xDEADBEEF -> readback 0xDE22BE44.
REQ-043 Read addr 0x2 (misaligned) and addr DEPTH*4 (out-of-range) -> rsp_err 1, rdata 0, memory unchanged.
REQ-044 Assert rst in the RD_WAIT cycle of a read -> no rsp_valid, INIT restarts, and the previously written data reads back 0.
REQ-045 Back-to-back requests held valid -> mem_stall high between acceptances; accepted count matches throughput in REQ-029.
